// File: rtl/mcr_mem_pkg.sv
// mcr_mem_pkg: shared state/client encodings and ROM region bases for the program-ROM arbiter
package mcr_mem_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, RD_DONE, WRITE} state_e;
    typedef enum logic {CLI_CPU, CLI_SND} client_e;
    localparam logic [15:0] CPU_BASE_DEF = 16'h0000;
    localparam logic [15:0] SND_BASE_DEF = 16'h8000;
endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: download, CPU fetch, sound fetch and BRAM signals of the ROM arbiter
interface rom_port_arbiter_if #(
    parameter int MEM_AW = 16,
    parameter int CPU_AW = 15,
    parameter int SND_AW = 14
);
    logic              dl_active;
    logic              dl_wr;
    logic [24:0]       dl_addr;
    logic [7:0]        dl_data;
    logic              cpu_req;
    logic [CPU_AW-1:0] cpu_addr;
    logic              cpu_ack;
    logic [7:0]        cpu_data;
    logic              snd_req;
    logic [SND_AW-1:0] snd_addr;
    logic              snd_ack;
    logic [7:0]        snd_data;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_d;
    logic [7:0]        mem_q;
    logic              rom_loaded;
    logic              wr_overflow;
    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, cpu_req, cpu_addr, snd_req, snd_addr, mem_q,
        input  cpu_ack, cpu_data, snd_ack, snd_data, mem_addr, mem_we, mem_d, rom_loaded, wr_overflow
    );
    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, cpu_req, cpu_addr, snd_req, snd_addr, mem_q,
        output cpu_ack, cpu_data, snd_ack, snd_data, mem_addr, mem_we, mem_d, rom_loaded, wr_overflow
    );
endinterface

// File: rtl/rom_wr_buffer.sv
// rom_wr_buffer: one-entry download byte buffer with sticky overflow flag
module rom_wr_buffer (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        wr_i,
    input  logic [24:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        drain_i,
    output logic        full_o,
    output logic [15:0] addr_o,
    output logic [7:0]  data_o,
    output logic        overflow_o
);
    logic        full_q, full_d, ovf_q, ovf_d, accept, load;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    // a byte arriving in the same cycle the entry drains refills it
    always_comb begin
        accept = wr_i && addr_i[24:16] == '0;
        load   = accept && (!full_q || drain_i);
        full_d = load || (full_q && !drain_i);
        ovf_d  = ovf_q || (accept && full_q && !drain_i);
        addr_d = load ? addr_i[15:0] : addr_q;
        data_d = load ? data_i : data_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            ovf_q  <= ovf_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_o     = full_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign overflow_o = ovf_q;
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one single-port program-ROM BRAM between the download writer
// and the round-robin main/sound CPU fetch ports
module rom_port_arbiter
    import mcr_mem_pkg::*;
#(
    parameter int                MEM_AW   = 16,
    parameter int                CPU_AW   = 15,
    parameter int                SND_AW   = 14,
    parameter logic [MEM_AW-1:0] CPU_BASE = MEM_AW'(CPU_BASE_DEF),
    parameter logic [MEM_AW-1:0] SND_BASE = MEM_AW'(SND_BASE_DEF)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    rom_port_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    client_e           rr_q, rr_d, cli_q, cli_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_d_q, mem_d_d;
    logic              cpu_ack_q, cpu_ack_d, snd_ack_q, snd_ack_d;
    logic [7:0]        cpu_data_q, cpu_data_d, snd_data_q, snd_data_d;
    logic              dl_active_q, rom_loaded_q, rom_loaded_d;
    logic              buf_full, buf_ovf, drain, cpu_win;
    logic [15:0]       buf_addr;
    logic [7:0]        buf_data;

    rom_wr_buffer u_buf (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .wr_i       (bus.dl_wr),
        .addr_i     (bus.dl_addr),
        .data_i     (bus.dl_data),
        .drain_i    (drain),
        .full_o     (buf_full),
        .addr_o     (buf_addr),
        .data_o     (buf_data),
        .overflow_o (buf_ovf)
    );

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        cli_d        = cli_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_d_d      = mem_d_q;
        cpu_ack_d    = 1'b0;
        snd_ack_d    = 1'b0;
        cpu_data_d   = cpu_data_q;
        snd_data_d   = snd_data_q;
        drain        = 1'b0;
        cpu_win      = bus.cpu_req && (!bus.snd_req || rr_q == CLI_SND);
        rom_loaded_d = rom_loaded_q || (dl_active_q && !bus.dl_active);
        case (state_q)
            IDLE: begin
                if (buf_full) begin
                    state_d    = WRITE;
                    drain      = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = MEM_AW'(buf_addr);
                    mem_d_d    = buf_data;
                end else if (!bus.dl_active && (bus.cpu_req || bus.snd_req)) begin
                    state_d    = RD_ADDR;
                    cli_d      = cpu_win ? CLI_CPU : CLI_SND;
                    rr_d       = cli_d;
                    mem_addr_d = cpu_win ? (CPU_BASE | MEM_AW'(bus.cpu_addr))
                                         : (SND_BASE | MEM_AW'(bus.snd_addr));
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            // BRAM output is valid here; capture so ack and data appear together in RD_DONE
            RD_WAIT: begin
                state_d    = RD_DONE;
                cpu_ack_d  = cli_q == CLI_CPU;
                snd_ack_d  = cli_q == CLI_SND;
                cpu_data_d = cli_q == CLI_CPU ? bus.mem_q : cpu_data_q;
                snd_data_d = cli_q == CLI_SND ? bus.mem_q : snd_data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_q         <= CLI_SND;
            cli_q        <= CLI_CPU;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_d_q      <= '0;
            cpu_ack_q    <= 1'b0;
            snd_ack_q    <= 1'b0;
            cpu_data_q   <= '0;
            snd_data_q   <= '0;
            dl_active_q  <= 1'b0;
            rom_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cli_q        <= cli_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_d_q      <= mem_d_d;
            cpu_ack_q    <= cpu_ack_d;
            snd_ack_q    <= snd_ack_d;
            cpu_data_q   <= cpu_data_d;
            snd_data_q   <= snd_data_d;
            dl_active_q  <= bus.dl_active;
            rom_loaded_q <= rom_loaded_d;
        end
    end

    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_data    = cpu_data_q;
    assign bus.snd_ack     = snd_ack_q;
    assign bus.snd_data    = snd_data_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_d       = mem_d_q;
    assign bus.rom_loaded  = rom_loaded_q;
    assign bus.wr_overflow = buf_ovf;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench with a BRAM model and a reference ROM image
module tb_rom_port_arbiter;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    int   cpu_acks = 0;
    logic [7:0]  ref_mem [65536];
    logic [7:0]  bram [65536];
    logic [7:0]  cpu_q [$];
    logic [7:0]  snd_q [$];
    logic [23:0] wr_q [$];
    int          ack_order [$];
    logic [7:0]  wd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    rom_port_arbiter_if bus ();

    rom_port_arbiter dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cpu_ack"}, bus.cpu_ack, 0);
        chk({tag, "_snd_ack"}, bus.snd_ack, 0);
        chk({tag, "_cpu_data"}, bus.cpu_data, 0);
        chk({tag, "_snd_data"}, bus.snd_data, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_d"}, bus.mem_d, 0);
        chk({tag, "_rom_loaded"}, bus.rom_loaded, 0);
        chk({tag, "_wr_overflow"}, bus.wr_overflow, 0);
    endtask

    task automatic cpu_read(input logic [14:0] a, input int exp_lat);
        logic [15:0] ma;
        int lat;
        ma = 16'h0000 | {1'b0, a};
        bus.cpu_addr = a;
        bus.cpu_req = 1'b1;
        cpu_q.push_back(ref_mem[ma]);
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!bus.cpu_ack && lat < 300);
        chk("cpu_ack_seen", bus.cpu_ack, 1);
        chk("cpu_mem_addr", bus.mem_addr, ma);
        if (exp_lat > 0) chk("cpu_latency", lat, exp_lat);
        bus.cpu_req = 1'b0;
        tick(1);
    endtask

    task automatic snd_read(input logic [13:0] a, input int exp_lat);
        logic [15:0] ma;
        int lat;
        ma = 16'h8000 | {2'b0, a};
        bus.snd_addr = a;
        bus.snd_req = 1'b1;
        snd_q.push_back(ref_mem[ma]);
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!bus.snd_ack && lat < 300);
        chk("snd_ack_seen", bus.snd_ack, 1);
        chk("snd_mem_addr", bus.mem_addr, ma);
        if (exp_lat > 0) chk("snd_latency", lat, exp_lat);
        bus.snd_req = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input bit lands);
        bus.dl_addr = a;
        bus.dl_data = d;
        bus.dl_wr = 1'b1;
        if (lands) begin
            wr_q.push_back({a[15:0], d});
            ref_mem[a[15:0]] = d;
        end
        tick(1);
        bus.dl_wr = 1'b0;
    endtask

    initial begin
        int acks0;
        bus.dl_active = 1'b0;
        bus.dl_wr = 1'b0;
        bus.dl_addr = '0;
        bus.dl_data = '0;
        bus.cpu_req = 1'b0;
        bus.cpu_addr = '0;
        bus.snd_req = 1'b0;
        bus.snd_addr = '0;
        bus.mem_q = '0;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'($urandom);
            bram[i] <= ref_mem[i];
        end
        fork
            forever begin
                @(posedge clk_sys);
                if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_d;
                bus.mem_q <= bram[bus.mem_addr];
            end
            forever begin
                @(negedge clk_sys);
                if (bus.cpu_ack) begin
                    chk("cpu_ack_expected", cpu_q.size() > 0, 1);
                    if (cpu_q.size() > 0) chk("cpu_data", bus.cpu_data, cpu_q.pop_front());
                    ack_order.push_back(0);
                    cpu_acks++;
                end
                if (bus.snd_ack) begin
                    chk("snd_ack_expected", snd_q.size() > 0, 1);
                    if (snd_q.size() > 0) chk("snd_data", bus.snd_data, snd_q.pop_front());
                    ack_order.push_back(1);
                end
                if (bus.mem_we) begin
                    chk("write_expected", wr_q.size() > 0, 1);
                    if (wr_q.size() > 0) chk("mem_write", {bus.mem_addr, bus.mem_d}, wr_q.pop_front());
                end
            end
            begin
                tick(3);
                chk_zero("reset");
                reset_n = 1'b1;
                ref_mem[16'h0123] = 8'hA5;
                bram[16'h0123] <= 8'hA5;
                tick(1);
                fork
                    cpu_read(15'h0123, 3);
                    begin
                        tick(1);
                        chk("t1_mem_addr_after_grant", bus.mem_addr, 16'h0123);
                    end
                join
                chk("t1_cpu_data_held", bus.cpu_data, 8'hA5);

                do_reset();
                ack_order.delete();
                ref_mem[16'h0010] = 8'h3C;
                bram[16'h0010] <= 8'h3C;
                ref_mem[16'h8010] = 8'hC3;
                bram[16'h8010] <= 8'hC3;
                tick(1);
                fork
                    begin
                        cpu_read(15'h0010, 3);
                        cpu_read(15'h0010, 0);
                    end
                    begin
                        snd_read(14'h0010, 0);
                        snd_read(14'h0010, 0);
                    end
                join
                chk("t2_ack_count", ack_order.size(), 4);
                for (int i = 0; i < 4 && i < ack_order.size(); i++) chk("t2_grant_order", ack_order[i], i % 2);

                fork
                    for (int i = 0; i < 40; i++) begin
                        cpu_read(15'($urandom), 0);
                        tick($urandom_range(0, 3));
                    end
                    for (int i = 0; i < 40; i++) begin
                        snd_read(14'($urandom), 0);
                        tick($urandom_range(0, 3));
                    end
                join

                chk("t3_rom_loaded_before", bus.rom_loaded, 0);
                bus.dl_active = 1'b1;
                tick(2);
                for (int i = 0; i < 4; i++) begin
                    dl_byte(25'(i), wd[i], 1'b1);
                    tick(3);
                end
                acks0 = cpu_acks;
                fork
                    cpu_read(15'h0002, 0);
                    begin
                        tick(10);
                        chk("t3_no_ack_during_dl", cpu_acks - acks0, 0);
                        chk("t3_rom_loaded_during", bus.rom_loaded, 0);
                        bus.dl_active = 1'b0;
                        tick(1);
                        chk("t3_rom_loaded_after", bus.rom_loaded, 1);
                    end
                join
                chk("t3_cpu_data", bus.cpu_data, 8'h33);
                chk("t3_writes_done", wr_q.size(), 0);

                dl_byte(25'h10000, 8'h77, 1'b0);
                tick(5);
                chk("t4_wr_overflow", bus.wr_overflow, 0);

                fork
                    cpu_read(15'h0100, 3);
                    begin
                        tick(2);
                        dl_byte(25'h04000, 8'h5A, 1'b1);
                        dl_byte(25'h04001, 8'h6B, 1'b0);
                    end
                join
                tick(4);
                chk("t5_wr_overflow", bus.wr_overflow, 1);
                chk("t5_writes_done", wr_q.size(), 0);
                chk("t5_rom_loaded_kept", bus.rom_loaded, 1);

                bus.cpu_addr = 15'h0200;
                bus.cpu_req = 1'b1;
                tick(2);
                reset_n = 1'b0;
                tick(1);
                chk_zero("t6");
                bus.cpu_req = 1'b0;
                tick(1);
                reset_n = 1'b1;
                tick(6);
                chk("t6_no_stray_ack", cpu_q.size(), 0);
                cpu_read(15'h0200, 3);
                tick(2);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
